// File: rtl/machine_cycle_controller_if.sv
// rtl/machine_cycle_controller_if.sv - bus and strobe bundle for the 4004 machine-cycle controller
interface machine_cycle_controller_if;
    logic [3:0] data_bus;
    logic       hold_req;
    logic [2:0] state;
    logic       sync;
    logic       addr_en;
    logic [1:0] addr_sel;
    logic       instruction_register_WE;
    logic       opr_sel;
    logic       operand_we;
    logic       second_cycle;
    logic       exec_en;
    logic       pc_inc;
    logic       hold_ack;

    // Core side drives the bus nibble and hold request, observes the phase strobes
    modport master (
        output data_bus,
        output hold_req,
        input  state,
        input  sync,
        input  addr_en,
        input  addr_sel,
        input  instruction_register_WE,
        input  opr_sel,
        input  operand_we,
        input  second_cycle,
        input  exec_en,
        input  pc_inc,
        input  hold_ack
    );

    // Controller side consumes the bus nibble and hold request, produces the strobes
    modport slave (
        input  data_bus,
        input  hold_req,
        output state,
        output sync,
        output addr_en,
        output addr_sel,
        output instruction_register_WE,
        output opr_sel,
        output operand_we,
        output second_cycle,
        output exec_en,
        output pc_inc,
        output hold_ack
    );
endinterface

// File: rtl/machine_cycle_controller.sv
// rtl/machine_cycle_controller.sv - 4004 eight-phase machine-cycle sequencer with two-word decode and bus hold
module machine_cycle_controller (
    input  logic                          clk_1,
    input  logic                          rst_n,
    machine_cycle_controller_if.slave     bus
);

    // HOLD sits outside the eight real phases; its low bits are zero so the
    // visible state reads as A1 while parked.
    typedef enum logic [3:0] {
        ST_A1   = 4'd0,
        ST_A2   = 4'd1,
        ST_A3   = 4'd2,
        ST_M1   = 4'd3,
        ST_M2   = 4'd4,
        ST_X1   = 4'd5,
        ST_X2   = 4'd6,
        ST_X3   = 4'd7,
        ST_HOLD = 4'd8
    } phase_t;

    phase_t     r_phase;
    phase_t     w_phase_nxt;
    logic       r_pending;
    logic       w_pending_nxt;
    logic       r_second;
    logic       w_second_nxt;
    logic [3:0] r_opr;
    logic [3:0] w_opr_nxt;
    logic       w_two_word;

    logic [2:0] w_state;
    logic       w_sync;
    logic       w_addr_en;
    logic [1:0] w_addr_sel;
    logic       w_ir_we;
    logic       w_opr_sel;
    logic       w_operand_we;
    logic       w_exec_en;
    logic       w_pc_inc;
    logic       w_hold_ack;

    // Two-word opcodes: JCN, JUN, JMS, ISZ, and FIM (0x2 with even OPA; odd OPA is SRC)
    always_comb begin
        w_two_word = 1'b0;
        case (r_opr)
            4'h1, 4'h4, 4'h5, 4'h7: w_two_word = 1'b1;
            4'h2:                   w_two_word = ~bus.data_bus[0];
            default:                w_two_word = 1'b0;
        endcase
    end

    // State, pending flag, second-cycle flag and latched OPR; reset aborts any instruction
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            r_phase   <= ST_A1;
            r_pending <= 1'b0;
            r_second  <= 1'b0;
            r_opr     <= 4'h0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_pending <= w_pending_nxt;
            r_second  <= w_second_nxt;
            r_opr     <= w_opr_nxt;
        end
    end

    // Next phase plus the OPR latch, two-word decision and pending-to-second transfer
    always_comb begin
        w_phase_nxt   = r_phase;
        w_pending_nxt = r_pending;
        w_second_nxt  = r_second;
        w_opr_nxt     = r_opr;
        case (r_phase)
            ST_A1: w_phase_nxt = ST_A2;
            ST_A2: w_phase_nxt = ST_A3;
            ST_A3: w_phase_nxt = ST_M1;
            ST_M1: begin
                w_phase_nxt = ST_M2;
                // Only an opcode fetch carries OPR; operand words must not disturb it
                if (!r_second) begin
                    w_opr_nxt = bus.data_bus;
                end
            end
            ST_M2: begin
                w_phase_nxt = ST_X1;
                // Second cycles never chain, whatever their operand looks like
                if (!r_second && w_two_word) begin
                    w_pending_nxt = 1'b1;
                end
            end
            ST_X1: w_phase_nxt = ST_X2;
            ST_X2: w_phase_nxt = ST_X3;
            ST_X3: begin
                // The transfer happens on leaving X3 whether we go to A1 or park
                w_phase_nxt   = bus.hold_req ? ST_HOLD : ST_A1;
                w_second_nxt  = r_pending;
                w_pending_nxt = 1'b0;
            end
            ST_HOLD: begin
                if (!bus.hold_req) begin
                    w_phase_nxt = ST_A1;
                end
            end
            default: w_phase_nxt = ST_A1;
        endcase
    end

    // Moore decode of the registered phase and flags; nothing here looks at the inputs
    always_comb begin
        w_state      = 3'd0;
        w_sync       = 1'b0;
        w_addr_en    = 1'b0;
        w_addr_sel   = 2'd0;
        w_ir_we      = 1'b0;
        w_opr_sel    = 1'b0;
        w_operand_we = 1'b0;
        w_exec_en    = 1'b0;
        w_pc_inc     = 1'b0;
        w_hold_ack   = 1'b0;
        if (r_phase == ST_HOLD) begin
            w_hold_ack = 1'b1;
        end else begin
            w_state = r_phase[2:0];
            case (r_phase)
                ST_A1: begin
                    w_addr_en  = 1'b1;
                    w_addr_sel = 2'd0;
                end
                ST_A2: begin
                    w_addr_en  = 1'b1;
                    w_addr_sel = 2'd1;
                end
                ST_A3: begin
                    w_addr_en  = 1'b1;
                    w_addr_sel = 2'd2;
                end
                ST_M1: begin
                    w_opr_sel    = 1'b1;
                    w_ir_we      = ~r_second;
                    w_operand_we = r_second;
                end
                ST_M2: begin
                    w_ir_we      = ~r_second;
                    w_operand_we = r_second;
                end
                ST_X1, ST_X2: begin
                    // First half of a two-word instruction leaves the X phases idle
                    w_exec_en = r_second | ~r_pending;
                end
                ST_X3: begin
                    w_exec_en = r_second | ~r_pending;
                    w_sync    = 1'b1;
                    w_pc_inc  = 1'b1;
                end
                default: begin
                    w_state = 3'd0;
                end
            endcase
        end
    end

    assign bus.state                   = w_state;
    assign bus.sync                    = w_sync;
    assign bus.addr_en                 = w_addr_en;
    assign bus.addr_sel                = w_addr_sel;
    assign bus.instruction_register_WE = w_ir_we;
    assign bus.opr_sel                 = w_opr_sel;
    assign bus.operand_we              = w_operand_we;
    assign bus.second_cycle            = (r_phase == ST_HOLD) ? 1'b0 : r_second;
    assign bus.exec_en                 = w_exec_en;
    assign bus.pc_inc                  = w_pc_inc;
    assign bus.hold_ack                = w_hold_ack;

endmodule

// File: tb/tb_machine_cycle_controller.sv
// tb/tb_machine_cycle_controller.sv - vector table and scoreboard bench for machine_cycle_controller
module tb_machine_cycle_controller;

    typedef struct packed {
        logic [2:0] state;
        logic       sync;
        logic       addr_en;
        logic [1:0] addr_sel;
        logic       ir_we;
        logic       opr_sel;
        logic       operand_we;
        logic       second_cycle;
        logic       exec_en;
        logic       pc_inc;
        logic       hold_ack;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic [3:0] db;
        logic       hr;
        outs_t      exp;
    } vec_t;

    logic  clk;
    logic  rst_n;
    vec_t  vecs[$];
    outs_t exp_q[$];
    int    n_checks;
    int    n_pass;

    machine_cycle_controller_if bus ();

    machine_cycle_controller dut (
        .clk_1 (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a phase, straight from the phase table
    function automatic outs_t dec(int ph, bit sec, bit pend, bit hold);
        outs_t o;
        o = '0;
        if (hold) begin
            o.hold_ack = 1'b1;
            return o;
        end
        o.state        = 3'(ph);
        o.sync         = (ph == 7);
        o.addr_en      = (ph < 3);
        o.addr_sel     = (ph < 3) ? 2'(ph) : 2'd0;
        o.ir_we        = !sec && (ph == 3 || ph == 4);
        o.opr_sel      = (ph == 3);
        o.operand_we   = sec && (ph == 3 || ph == 4);
        o.second_cycle = sec;
        o.exec_en      = (ph >= 5) && (sec || !pend);
        o.pc_inc       = (ph == 7);
        return o;
    endfunction

    function automatic outs_t grab();
        outs_t o;
        o.state        = bus.state;
        o.sync         = bus.sync;
        o.addr_en      = bus.addr_en;
        o.addr_sel     = bus.addr_sel;
        o.ir_we        = bus.instruction_register_WE;
        o.opr_sel      = bus.opr_sel;
        o.operand_we   = bus.operand_we;
        o.second_cycle = bus.second_cycle;
        o.exec_en      = bus.exec_en;
        o.pc_inc       = bus.pc_inc;
        o.hold_ack     = bus.hold_ack;
        return o;
    endfunction

    function automatic vec_t mk(logic r, logic [3:0] d, logic h, outs_t e);
        vec_t v;
        v.rst_n = r;
        v.db    = d;
        v.hr    = h;
        v.exp   = e;
        return v;
    endfunction

    // One full machine cycle: opcode/operand nibbles in M1/M2, optional hold requests
    task automatic add_cycle(bit sec, bit two, logic [3:0] m1, logic [3:0] m2, bit hr_x3, bit hr_m1);
        for (int ph = 0; ph < 8; ph++) begin
            logic [3:0] d;
            logic       h;
            d = (ph == 3) ? m1 : ((ph == 4) ? m2 : 4'h0);
            h = (ph == 7 && hr_x3) || (ph == 3 && hr_m1);
            vecs.push_back(mk(1'b1, d, h, dec(ph, sec, two && ph >= 5, 1'b0)));
        end
    endtask

    task automatic add_hold(logic h);
        vecs.push_back(mk(1'b1, 4'h0, h, dec(0, 1'b0, 1'b0, 1'b1)));
    endtask

    task automatic check(string name, outs_t got, outs_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h want=%h (state/sync/aen/asel/irwe/oprsel/opwe/sec/exec/pcinc/hack)",
                     name, got, want);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.data_bus  = 4'h0;
        bus.hold_req  = 1'b0;

        // NOP free-run
        add_cycle(0, 0, 4'h0, 4'h0, 0, 0);
        add_cycle(0, 0, 4'h0, 4'h0, 0, 0);
        // JUN then its operand cycle
        add_cycle(0, 1, 4'h4, 4'h0, 0, 0);
        add_cycle(1, 0, 4'h0, 4'h0, 0, 0);
        // FIM, operand looks like JCN: no third cycle
        add_cycle(0, 1, 4'h2, 4'h0, 0, 0);
        add_cycle(1, 0, 4'h1, 4'h1, 0, 0);
        // SRC is single-word, then opcode fetch resumes
        add_cycle(0, 0, 4'h2, 4'h1, 0, 0);
        add_cycle(0, 0, 4'h0, 4'h0, 0, 0);
        // ISZ two-word; 0x3 with even OPA single-word
        add_cycle(0, 1, 4'h7, 4'h6, 0, 0);
        add_cycle(1, 0, 4'h0, 4'h0, 0, 0);
        add_cycle(0, 0, 4'h3, 4'h0, 0, 0);
        // Three-clock park
        add_cycle(0, 0, 4'h0, 4'h0, 1, 0);
        add_hold(1'b1);
        add_hold(1'b1);
        add_hold(1'b0);
        add_cycle(0, 0, 4'h0, 4'h0, 0, 0);
        // JMS parked for one clock: the second cycle follows the park
        add_cycle(0, 1, 4'h5, 4'h3, 1, 0);
        add_hold(1'b0);
        add_cycle(1, 0, 4'h0, 4'h0, 0, 0);
        // hold_req outside X3 is ignored
        add_cycle(0, 0, 4'h0, 4'h0, 0, 1);
        add_cycle(0, 0, 4'h0, 4'h0, 0, 0);
        // Reset during M2 of a JMS first cycle
        for (int ph = 0; ph < 4; ph++) begin
            vecs.push_back(mk(1'b1, (ph == 3) ? 4'h5 : 4'h0, 1'b0, dec(ph, 1'b0, 1'b0, 1'b0)));
        end
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, dec(4, 1'b0, 1'b0, 1'b0)));
        add_cycle(0, 0, 4'h0, 4'h0, 0, 0);
        // Reset while parked with a pending second cycle
        add_cycle(0, 1, 4'h4, 4'h0, 1, 0);
        vecs.push_back(mk(1'b0, 4'h0, 1'b1, dec(0, 1'b0, 1'b0, 1'b1)));
        add_cycle(0, 0, 4'h0, 4'h0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_state", grab(), dec(0, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            rst_n        = vecs[i].rst_n;
            bus.data_bus = vecs[i].db;
            bus.hold_req = vecs[i].hr;
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty vec%0d got=empty want=entry", i);
            end else begin
                check($sformatf("vec%0d", i), grab(), exp_q.pop_front());
            end
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
